// File: rtl/pipe_execute_stage_pkg.sv
// Shared encodings for the Y86-64 execute stage: status codes, icodes,
// ALU functions and condition codes.
package pipe_execute_stage_pkg;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] IIADDQ  = 4'hC;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufun_t;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_t;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational Y86 ALU: valE = aluB OP aluA with {ZF,SF,OF}.
module pipe_alu
  import pipe_execute_stage_pkg::*;
#(
  parameter int unsigned WORD_W = 64
) (
  input  logic [WORD_W-1:0] alu_a,
  input  logic [WORD_W-1:0] alu_b,
  input  alufun_t           alufun,
  output logic [WORD_W-1:0] val_e,
  output logic [2:0]        flags
);

  logic sa;
  logic sb;
  logic se;
  logic of;

  always_comb begin
    val_e = '0;
    case (alufun)
      ALU_ADD: val_e = alu_b + alu_a;
      ALU_SUB: val_e = alu_b - alu_a;
      ALU_AND: val_e = alu_b & alu_a;
      ALU_XOR: val_e = alu_b ^ alu_a;
      default: val_e = '0;
    endcase
  end

  assign sa = alu_a[WORD_W-1];
  assign sb = alu_b[WORD_W-1];
  assign se = val_e[WORD_W-1];

  always_comb begin
    of = 1'b0;
    case (alufun)
      ALU_ADD: of = (sa == sb) && (se != sb);
      ALU_SUB: of = (sa != sb) && (se != sb);
      default: of = 1'b0;
    endcase
  end

  assign flags = {(val_e == '0), se, of};

endmodule

// File: rtl/pipe_execute_stage.sv
// Y86-64 execute stage: E pipeline register, operand/function muxes, ALU,
// gated condition-code register, branch/cmov condition and dstE cancellation.
module pipe_execute_stage
  import pipe_execute_stage_pkg::*;
#(
  parameter int unsigned WORD_W    = 64,
  parameter bit          HAS_IADDQ = 1'b1,
  parameter logic [2:0]  CC_RESET  = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WORD_W-1:0] d_valC,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_dstM,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] e_valE,
  output logic              e_cnd,
  output logic [3:0]        e_dstE,
  output logic [2:0]        cc
);

  localparam logic [WORD_W-1:0] WORD_BYTES = WORD_W'(WORD_W / 8);

  logic [WORD_W-1:0] E_valC;
  logic [WORD_W-1:0] E_valB;
  logic [3:0]        E_dstE;
  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  alufun_t           alufun;
  logic [2:0]        alu_flags;
  logic              is_iaddq;
  logic              set_cc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_stat  <= SBUB;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
    end else if (!E_stall) begin
      if (E_bubble) begin
        E_stat  <= SBUB;
        E_icode <= INOP;
        E_ifun  <= 4'h0;
        E_valC  <= '0;
        E_valA  <= '0;
        E_valB  <= '0;
        E_dstE  <= RNONE;
        E_dstM  <= RNONE;
      end else begin
        E_stat  <= d_stat;
        E_icode <= d_icode;
        E_ifun  <= d_ifun;
        E_valC  <= d_valC;
        E_valA  <= d_valA;
        E_valB  <= d_valB;
        E_dstE  <= d_dstE;
        E_dstM  <= d_dstM;
      end
    end
  end

  assign is_iaddq = HAS_IADDQ && (E_icode == IIADDQ);

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      IRRMOVQ:                   alu_a = E_valA;
      IOPQ:    begin alu_a = E_valA; alu_b = E_valB; end
      IIRMOVQ:                   alu_a = E_valC;
      IRMMOVQ, IMRMOVQ: begin alu_a = E_valC; alu_b = E_valB; end
      ICALL, IPUSHQ:    begin alu_a = '0 - WORD_BYTES; alu_b = E_valB; end
      IRET, IPOPQ:      begin alu_a = WORD_BYTES; alu_b = E_valB; end
      IIADDQ: begin
        if (is_iaddq) begin
          alu_a = E_valC;
          alu_b = E_valB;
        end
      end
      default: begin
        alu_a = '0;
        alu_b = '0;
      end
    endcase
  end

  assign alufun = (E_icode == IOPQ) ? alufun_t'(E_ifun[1:0]) : ALU_ADD;

  pipe_alu #(
    .WORD_W (WORD_W)
  ) u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alufun (alufun),
    .val_e  (e_valE),
    .flags  (alu_flags)
  );

  // A bubble, or any exception already downstream, must not disturb the flags.
  assign set_cc = ((E_icode == IOPQ) || is_iaddq) && (E_stat != SBUB)
                  && !is_exc(m_stat) && !is_exc(W_stat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      cc <= alu_flags;
    end
  end

  always_comb begin
    e_cnd = 1'b0;
    case (E_ifun)
      C_YES:   e_cnd = 1'b1;
      C_LE:    e_cnd = (cc[1] ^ cc[0]) | cc[2];
      C_L:     e_cnd = cc[1] ^ cc[0];
      C_E:     e_cnd = cc[2];
      C_NE:    e_cnd = !cc[2];
      C_GE:    e_cnd = !(cc[1] ^ cc[0]);
      C_G:     e_cnd = !(cc[1] ^ cc[0]) && !cc[2];
      default: e_cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == IRRMOVQ) && !e_cnd) ? RNONE : E_dstE;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Self-checking bench for pipe_execute_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model of the stage.
module tb_pipe_execute_stage;
  import pipe_execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_stall, E_bubble;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [2:0]  m_stat, W_stat;

  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstM, e_dstE;
  logic [63:0] E_valA, e_valE;
  logic        e_cnd;
  logic [2:0]  cc;

  logic [2:0]  s_E_stat;
  logic [3:0]  s_E_icode, s_E_ifun, s_E_dstM, s_e_dstE;
  logic [31:0] s_E_valA, s_e_valE;
  logic        s_e_cnd;
  logic [2:0]  s_cc;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [2:0]  me_stat;
  logic [3:0]  me_icode, me_ifun, me_dstE, me_dstM;
  logic [63:0] me_valC, me_valA, me_valB;
  logic [2:0]  m_cc;

  always #5 clk = ~clk;

  pipe_execute_stage #(.WORD_W(64), .HAS_IADDQ(1'b1), .CC_RESET(3'b100)) dut (
    .clk(clk), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM),
    .E_valA(E_valA), .e_valE(e_valE), .e_cnd(e_cnd), .e_dstE(e_dstE), .cc(cc)
  );

  pipe_execute_stage #(.WORD_W(32), .HAS_IADDQ(1'b1), .CC_RESET(3'b100)) dut32 (
    .clk(clk), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC[31:0]), .d_valA(d_valA[31:0]), .d_valB(d_valB[31:0]),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(s_E_stat), .E_icode(s_E_icode), .E_ifun(s_E_ifun), .E_dstM(s_E_dstM),
    .E_valA(s_E_valA), .e_valE(s_e_valE), .e_cnd(s_e_cnd), .e_dstE(s_e_dstE), .cc(s_cc)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_val_e(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5, 4'hC: return b + c;
      4'h6: begin
        case (fn[1:0])
          2'd0: return b + a;
          2'd1: return b - a;
          2'd2: return b & a;
          default: return b ^ a;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  // Overflow from a 65-bit sign-extended result that no longer fits in 64 bits.
  function automatic logic [2:0] ref_flags(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    logic [63:0] r;
    logic [64:0] wide;
    logic        ovf;
    r    = ref_val_e(ic, fn, a, b, c);
    ovf  = 1'b0;
    wide = '0;
    if (ic == 4'hC) begin
      wide = {b[63], b} + {c[63], c};
      ovf  = wide[64] != wide[63];
    end else if (fn[1:0] == 2'd0) begin
      wide = {b[63], b} + {a[63], a};
      ovf  = wide[64] != wide[63];
    end else if (fn[1:0] == 2'd1) begin
      wide = {b[63], b} - {a[63], a};
      ovf  = wide[64] != wide[63];
    end
    return {(r == 64'd0), r[63], ovf};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] f);
    logic zf, lt;
    zf = f[2];
    lt = f[1] != f[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_bubble();
    me_stat = 3'd0; me_icode = 4'h1; me_ifun = 4'h0;
    me_valC = '0; me_valA = '0; me_valB = '0;
    me_dstE = 4'hF; me_dstM = 4'hF;
  endtask

  task automatic model_reset();
    model_bubble();
    m_cc = 3'b100;
  endtask

  task automatic model_edge();
    if ((me_icode == 4'h6 || me_icode == 4'hC) && me_stat != 3'd0
        && !(m_stat inside {3'd2, 3'd3, 3'd4}) && !(W_stat inside {3'd2, 3'd3, 3'd4}))
      m_cc = ref_flags(me_icode, me_ifun, me_valA, me_valB, me_valC);
    if (!E_stall) begin
      if (E_bubble) model_bubble();
      else begin
        me_stat = d_stat; me_icode = d_icode; me_ifun = d_ifun;
        me_valC = d_valC; me_valA = d_valA; me_valB = d_valB;
        me_dstE = d_dstE; me_dstM = d_dstM;
      end
    end
  endtask

  task automatic check_all();
    logic c;
    c = ref_cnd(me_ifun, m_cc);
    check_val("E_stat", 64'(E_stat), 64'(me_stat));
    check_val("E_icode", 64'(E_icode), 64'(me_icode));
    check_val("E_ifun", 64'(E_ifun), 64'(me_ifun));
    check_val("E_dstM", 64'(E_dstM), 64'(me_dstM));
    check_val("E_valA", E_valA, me_valA);
    check_val("e_valE", e_valE, ref_val_e(me_icode, me_ifun, me_valA, me_valB, me_valC));
    check_val("e_cnd", 64'(e_cnd), 64'(c));
    check_val("e_dstE", 64'(e_dstE), 64'((me_icode == 4'h2 && !c) ? 4'hF : me_dstE));
    check_val("cc", 64'(cc), 64'(m_cc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] de, input logic [3:0] dm);
    d_stat = st; d_icode = ic; d_ifun = fn;
    d_valC = c; d_valA = a; d_valB = b; d_dstE = de; d_dstM = dm;
    tick();
  endtask

  task automatic nop();
    load(SAOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_val({tag, "_cc"}, 64'(cc), 64'h4);
    check_val({tag, "_icode"}, 64'(E_icode), 64'h1);
    check_val({tag, "_stat"}, 64'(E_stat), 64'h0);
    check_val({tag, "_dstE"}, 64'(e_dstE), 64'hF);
    check_val({tag, "_valE"}, e_valE, 64'h0);
    check_val({tag, "_cnd"}, 64'(e_cnd), 64'h1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    d_stat = SAOK; d_icode = 4'h1; d_ifun = 4'h0;
    d_valC = '0; d_valA = '0; d_valB = '0; d_dstE = 4'hF; d_dstM = 4'hF;
    m_stat = SAOK; W_stat = SAOK;
    model_reset();
    #12;
    check_val("rst_valE", e_valE, 64'h0);
    check_val("rst_cnd", 64'(e_cnd), 64'h1);
    check_val("rst_dstE", 64'(e_dstE), 64'hF);
    check_val("rst_cc", 64'(cc), 64'h4);
    reset = 1'b0;

    // sub 5-5 then cmovne
    load(SAOK, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1, 4'hF);
    check_val("sub_valE", e_valE, 64'h0);
    load(SAOK, 4'h2, 4'h4, 64'd0, 64'd7, 64'd0, 4'h3, 4'hF);
    check_val("sub_cc", 64'(cc), 64'h4);
    check_val("cmovne_dstE", 64'(e_dstE), 64'hF);

    // signed overflow on add, then jl / jle
    load(SAOK, 4'h6, 4'h0, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'h2, 4'hF);
    check_val("ovf_valE", e_valE, 64'h8000_0000_0000_0000);
    load(SAOK, 4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    check_val("ovf_cc", 64'(cc), 64'h3);
    check_val("jl_cnd", 64'(e_cnd), 64'h0);
    load(SAOK, 4'h7, 4'h1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    check_val("jle_cnd", 64'(e_cnd), 64'h0);

    // downstream exceptions gate the CC write
    m_stat = SADR;
    load(SAOK, 4'h6, 4'h2, 64'd0, 64'd0, 64'd0, 4'h1, 4'hF);
    nop();
    check_val("madr_cc", 64'(cc), 64'h3);
    m_stat = SAOK;
    load(SAOK, 4'h6, 4'h2, 64'd0, 64'd0, 64'd0, 4'h1, 4'hF);
    nop();
    check_val("and_cc", 64'(cc), 64'h4);
    W_stat = SINS;
    load(SAOK, 4'h6, 4'h0, 64'd0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'h1, 4'hF);
    nop();
    check_val("wins_cc", 64'(cc), 64'h4);
    W_stat = SAOK;

    // stack pointer adjust, both widths
    load(SAOK, 4'h8, 4'h0, 64'h200, 64'd0, 64'h100, 4'h4, 4'hF);
    check_val("call_valE", e_valE, 64'hF8);
    check_val("call32_valE", 64'(s_e_valE), 64'hFC);
    load(SAOK, 4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h5);
    check_val("pop_valE", e_valE, 64'h108);

    // stall holds E (and wins over bubble), CC still written
    load(SAOK, 4'h6, 4'h3, 64'd0, 64'd1, 64'd3, 4'h6, 4'hF);
    check_val("xor_valE", e_valE, 64'h2);
    E_stall = 1'b1;
    load(SAOK, 4'h6, 4'h0, 64'd0, 64'd9, 64'd9, 4'h7, 4'h5);
    E_bubble = 1'b1;
    tick();
    check_val("stall_icode", 64'(E_icode), 64'h6);
    check_val("stall_ifun", 64'(E_ifun), 64'h3);
    check_val("stall_valA", E_valA, 64'h1);
    check_val("stall_cc", 64'(cc), 64'h0);
    E_stall = 1'b0;
    tick();
    check_val("bub_icode", 64'(E_icode), 64'h1);
    check_val("bub_stat", 64'(E_stat), 64'h0);
    E_bubble = 1'b0;
    load(SBUB, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1, 4'hF);
    nop();
    check_val("bubstat_cc", 64'(cc), 64'h0);

    // iaddq and mid-stream async reset
    load(SAOK, 4'hC, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 4'h2, 4'hF);
    check_val("iaddq_valE", e_valE, 64'h0);
    async_reset_check("midrst");

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 7) == 0);
      d_stat   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : SAOK;
      d_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      d_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      d_valA   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      d_valB   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      d_valC   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      d_dstE   = 4'($urandom_range(0, 15));
      d_dstM   = 4'($urandom_range(0, 15));
      m_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : SAOK;
      W_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : SAOK;
      tick();
      check_all();
      if (i == 400) async_reset_check("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
